// File: rtl/frame_dump_arbiter.sv
// frame_dump_arbiter: owns the single BRAM read port in the clk25 domain.
// VGA fetches always win the port. A frame dump reads pixels only in cycles
// VGA leaves free and streams each 12-bit pixel as two UART bytes
// (high nibble first, then the low byte) over the start_tx/tx_busy handshake.
module frame_dump_arbiter #(
  parameter int ADDR_W = 19,
  parameter int NPIX   = 76800,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_db,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  input  logic              dump_start,
  input  logic              dump_abort,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [11:0]       bram_rd_data,
  input  logic              tx_busy,
  output logic              start_tx,
  output logic [7:0]        tx_data,
  output logic              vga_grant,
  output logic              dump_active,
  output logic              dump_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_WAIT, S_SEND_HI, S_ACK_HI,
    S_DRAIN_HI, S_SEND_LO, S_ACK_LO, S_DRAIN_LO
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [11:0]         pix_q, pix_d;
  logic [RD_LAT:0]     tag_q, tag_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                vga_grant_q, vga_grant_d;
  logic                start_tx_q, start_tx_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                dump_active_q, dump_active_d;
  logic                dump_done_q, dump_done_d;
  logic                launch_s;

  // Port arbitration and read-tag pipe: VGA first, dump read only when free.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    vga_grant_d = vga_req;
    launch_s    = 1'b0;
    if (vga_req) begin
      rd_addr_d = vga_addr;
    end else if ((state_q == S_REQ) && !dump_abort) begin
      rd_addr_d = pix_cnt_q;
      launch_s  = 1'b1;
    end else begin
      rd_addr_d = rd_addr_q;
    end
    // The tag marks when the dump's read data is valid on bram_rd_data.
    tag_d    = '0;
    tag_d[0] = launch_s;
    for (int i = 1; i <= RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (state_q == S_IDLE) begin
      tag_d = '0;
    end else begin
      tag_d = tag_d;
    end
  end

  // Dump sequencer: read pixel, send high byte, send low byte, advance.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    pix_d       = pix_q;
    start_tx_d  = 1'b0;
    tx_data_d   = tx_data_q;
    dump_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          pix_cnt_d = '0;
          state_d   = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (dump_abort) begin
          state_d = S_IDLE;
        end else if (!vga_req) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (dump_abort) begin
          state_d = S_IDLE;
        end else if (tag_q[RD_LAT]) begin
          pix_d   = bram_rd_data;
          state_d = S_SEND_HI;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_SEND_HI: begin
        if (dump_abort) begin
          state_d = S_IDLE;
        end else if (!tx_busy) begin
          start_tx_d = 1'b1;
          tx_data_d  = {4'h0, pix_q[11:8]};
          state_d    = S_ACK_HI;
        end else begin
          state_d = S_SEND_HI;
        end
      end
      S_ACK_HI: begin
        if (tx_busy) begin
          state_d = S_DRAIN_HI;
        end else begin
          state_d = S_ACK_HI;
        end
      end
      S_DRAIN_HI: begin
        if (!tx_busy) begin
          state_d = S_SEND_LO;
        end else begin
          state_d = S_DRAIN_HI;
        end
      end
      S_SEND_LO: begin
        // Once the high byte is out the low byte always follows, abort or not.
        start_tx_d = 1'b1;
        tx_data_d  = pix_q[7:0];
        state_d    = S_ACK_LO;
      end
      S_ACK_LO: begin
        if (tx_busy) begin
          state_d = S_DRAIN_LO;
        end else begin
          state_d = S_ACK_LO;
        end
      end
      S_DRAIN_LO: begin
        if (tx_busy) begin
          state_d = S_DRAIN_LO;
        end else if (pix_cnt_q == LAST_PIX) begin
          dump_done_d = 1'b1;
          state_d     = S_IDLE;
        end else if (dump_abort) begin
          state_d = S_IDLE;
        end else begin
          pix_cnt_d = pix_cnt_q + ADDR_W'(1);
          state_d   = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    dump_active_d = (state_d != S_IDLE);
  end

  // State and output registers, cleared asynchronously by rst_db.
  always_ff @(posedge clk or negedge rst_db) begin
    if (!rst_db) begin
      state_q       <= S_IDLE;
      pix_cnt_q     <= '0;
      pix_q         <= 12'h000;
      tag_q         <= '0;
      rd_addr_q     <= '0;
      vga_grant_q   <= 1'b0;
      start_tx_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      dump_active_q <= 1'b0;
      dump_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pix_cnt_q     <= pix_cnt_d;
      pix_q         <= pix_d;
      tag_q         <= tag_d;
      rd_addr_q     <= rd_addr_d;
      vga_grant_q   <= vga_grant_d;
      start_tx_q    <= start_tx_d;
      tx_data_q     <= tx_data_d;
      dump_active_q <= dump_active_d;
      dump_done_q   <= dump_done_d;
    end
  end

  assign bram_rd_addr = rd_addr_q;
  assign vga_grant    = vga_grant_q;
  assign start_tx     = start_tx_q;
  assign tx_data      = tx_data_q;
  assign dump_active  = dump_active_q;
  assign dump_done    = dump_done_q;

endmodule

// File: tb/tb_frame_dump_arbiter.sv
// Directed testbench for frame_dump_arbiter with a 1-cycle BRAM model and a
// small uart_tx model that stays busy for a fixed number of cycles per byte.
module tb_frame_dump_arbiter;

  localparam int ADDR_W = 19;
  localparam int NPIX   = 128;
  localparam int RD_LAT = 1;
  localparam int BUSY   = 3;

  logic              clk;
  logic              rst_db;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic              dump_start;
  logic              dump_abort;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [11:0]       bram_rd_data;
  logic              tx_busy;
  logic              start_tx;
  logic [7:0]        tx_data;
  logic              vga_grant;
  logic              dump_active;
  logic              dump_done;

  frame_dump_arbiter #(.ADDR_W(ADDR_W), .NPIX(NPIX), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_db(rst_db), .vga_req(vga_req), .vga_addr(vga_addr),
    .dump_start(dump_start), .dump_abort(dump_abort),
    .bram_rd_addr(bram_rd_addr), .bram_rd_data(bram_rd_data),
    .tx_busy(tx_busy), .start_tx(start_tx), .tx_data(tx_data),
    .vga_grant(vga_grant), .dump_active(dump_active), .dump_done(dump_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] mem [0:1023];
  logic [7:0]  byte_q [$];
  int          busy_cnt = 0;
  logic [7:0]  held_data = 8'h00;
  int          ovl_err = 0;
  int          stab_err = 0;
  int          start_cnt = 0;
  int          done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] pix_val(input int i);
    return 12'((i * 13 + 341) & 4095);
  endfunction

  // BRAM read model with one cycle of latency.
  always @(posedge clk) bram_rd_data <= mem[bram_rd_addr[9:0]];

  // uart_tx model: captures each byte and stays busy for BUSY cycles.
  always @(posedge clk or negedge rst_db) begin
    if (!rst_db) begin
      busy_cnt <= 0;
    end else if (start_tx) begin
      if (tx_busy) ovl_err <= ovl_err + 1;
      busy_cnt  <= BUSY;
      held_data <= tx_data;
      byte_q.push_back(tx_data);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (tx_data !== held_data) stab_err <= stab_err + 1;
    end
  end
  assign tx_busy = (busy_cnt != 0);

  // Pulse counters for start_tx and dump_done.
  always @(posedge clk) begin
    if (start_tx)  start_cnt <= start_cnt + 1;
    if (dump_done) done_cnt  <= done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_addr"},   32'(bram_rd_addr), 32'd0);
    check_eq({pfx, "_start"},  32'(start_tx),     32'd0);
    check_eq({pfx, "_data"},   32'(tx_data),      32'd0);
    check_eq({pfx, "_grant"},  32'(vga_grant),    32'd0);
    check_eq({pfx, "_active"}, 32'(dump_active),  32'd0);
    check_eq({pfx, "_done"},   32'(dump_done),    32'd0);
  endtask

  // Count captured bytes from base that differ from pixels 0..np-1.
  function automatic int frame_errs(input int base, input int np);
    int errs = 0;
    logic [11:0] v;
    for (int p = 0; p < np; p++) begin
      v = pix_val(p);
      if (byte_q[base + 2*p]     !== {4'h0, v[11:8]}) errs++;
      if (byte_q[base + 2*p + 1] !== v[7:0])          errs++;
    end
    return errs;
  endfunction

  initial begin
    int sbase, dbase, bbase, n;
    bit found, mid_sent;
    logic [11:0] v;

    for (int i = 0; i < 1024; i++) mem[i] = pix_val(i);
    rst_db = 1'b1; vga_req = 1'b0; vga_addr = '0;
    dump_start = 1'b0; dump_abort = 1'b0;
    #2 rst_db = 1'b0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_db = 1'b1;
    tick();

    // VGA only: address follows vga_addr one cycle later, never a byte.
    sbase = start_cnt;
    vga_req = 1'b1;
    for (int a = 0; a < 640; a++) begin
      vga_addr = ADDR_W'(a);
      tick();
      check_eq("vga_addr_follow", 32'(bram_rd_addr), 32'(a));
      check_eq("vga_grant_high", 32'(vga_grant), 32'd1);
    end
    tick();
    check_eq("vga_only_no_tx", 32'(start_cnt - sbase), 32'd0);

    // Full frame with idle VGA: first-byte latency, then every byte in order.
    vga_req = 1'b0;
    tick();
    check_eq("grant_low", 32'(vga_grant), 32'd0);
    sbase = start_cnt; dbase = done_cnt; bbase = byte_q.size();
    pulse_start();
    check_eq("active_after_start", 32'(dump_active), 32'd1);
    n = 0; found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      tick();
      if (start_tx) begin n = i; found = 1'b1; end
    end
    check_eq("first_start_latency", 32'(n), 32'(RD_LAT + 3));
    v = pix_val(0);
    check_eq("first_byte_hi", 32'(tx_data), 32'({4'h0, v[11:8]}));
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      if (dump_done) begin
        found = 1'b1;
        check_eq("active_falls_with_done", 32'(dump_active), 32'd0);
      end
    end
    check_eq("frame1_done_seen", 32'(found), 32'd1);
    tick();
    check_eq("done_one_cycle", 32'(dump_done), 32'd0);
    check_eq("frame1_done_count", 32'(done_cnt - dbase), 32'd1);
    check_eq("frame1_start_count", 32'(start_cnt - sbase), 32'(2 * NPIX));
    check_eq("frame1_byte_count", 32'(byte_q.size() - bbase), 32'(2 * NPIX));
    check_eq("frame1_bytes", 32'(frame_errs(bbase, NPIX)), 32'd0);

    // Contention: VGA holds the port for 50 cycles after dump_start.
    tick(); tick();
    sbase = start_cnt; dbase = done_cnt; bbase = byte_q.size();
    vga_req = 1'b1; vga_addr = ADDR_W'(700);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      vga_addr = ADDR_W'(700 + i);
      tick();
    end
    check_eq("contention_vga_addr", 32'(bram_rd_addr), 32'd749);
    check_eq("contention_no_tx", 32'(start_cnt - sbase), 32'd0);
    check_eq("contention_active", 32'(dump_active), 32'd1);
    vga_req = 1'b0;
    tick();
    check_eq("dump_read_addr0", 32'(bram_rd_addr), 32'd0);
    check_eq("dump_read_grant", 32'(vga_grant), 32'd0);

    // Mid-dump dump_start is ignored; abort in ACK_HI of pixel 5 still sends its low byte.
    found = 1'b0; mid_sent = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      tick();
      if (dump_start) begin
        dump_start = 1'b0;
      end else if (!mid_sent && (start_cnt - sbase) >= 5) begin
        dump_start = 1'b1;
        mid_sent = 1'b1;
      end
      if (start_tx && (start_cnt - sbase) == 10) begin
        found = 1'b1;
        dump_abort = 1'b1;
      end
    end
    dump_start = 1'b0;
    check_eq("pix5_hi_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (!dump_active) found = 1'b1;
    end
    dump_abort = 1'b0;
    check_eq("abort_to_idle", 32'(found), 32'd1);
    tick(); tick(); tick();
    check_eq("abort_start_count", 32'(start_cnt - sbase), 32'd12);
    check_eq("abort_no_done", 32'(done_cnt - dbase), 32'd0);
    check_eq("abort_bytes", 32'(frame_errs(bbase, 6)), 32'd0);

    // Retrigger from IDLE restarts at pixel 0; random VGA contention throughout.
    sbase = start_cnt; dbase = done_cnt; bbase = byte_q.size();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 40000 && !found; i++) begin
      vga_req  = ($urandom_range(0, 3) == 0);
      vga_addr = ADDR_W'($urandom_range(0, 1023));
      tick();
      if (dump_done) found = 1'b1;
    end
    vga_req = 1'b0;
    check_eq("frame2_done_seen", 32'(found), 32'd1);
    tick();
    check_eq("frame2_start_count", 32'(start_cnt - sbase), 32'(2 * NPIX));
    check_eq("frame2_bytes", 32'(frame_errs(bbase, NPIX)), 32'd0);

    // Async reset while draining the low byte of pixel 100.
    sbase = start_cnt;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      if (start_tx && (start_cnt - sbase) == 201) found = 1'b1;
    end
    check_eq("pix100_lo_seen", 32'(found), 32'd1);
    tick(); tick();
    check_eq("in_drain_lo_active", 32'(dump_active), 32'd1);
    #2 rst_db = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1 rst_db = 1'b1;
    tick();
    bbase = byte_q.size();
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (byte_q.size() >= bbase + 2) found = 1'b1;
    end
    check_eq("restart_seen", 32'(found), 32'd1);
    check_eq("restart_bytes", 32'(frame_errs(bbase, 1)), 32'd0);

    check_eq("no_start_while_busy", 32'(ovl_err), 32'd0);
    check_eq("tx_data_stable", 32'(stab_err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_dump_arbiter.md
Name: frame_dump_arbiter

Overview:
- Owns the single BRAM read port in the clk25 domain and shares it between two requesters: the VGA fetch path and the UART frame-dump path.
- VGA always has priority. Dump reads are only issued in cycles where VGA is not requesting.
- Sequences a full-frame dump: each 12-bit pixel is read and sent as two UART bytes, using the uart_tx start_tx/tx_busy handshake.
- Sits between vga_ctrl, bram_mem (read side) and uart_tx. It replaces the ad-hoc read-address mux and echo/dump logic in the top level.

Parameters:
- ADDR_W, 19, BRAM address width.
- NPIX, 76800, pixels per frame (320*240); the dump covers addresses 0..NPIX-1.
- RD_LAT, 1, BRAM read latency in clk cycles, counted from registered address to valid data.

Ports:
- clk  in  1  pixel/UART clock (clk25 domain).
- rst_db  in  1  asynchronous active-low reset.
- vga_req  in  1  VGA needs the read port this cycle.
- vga_addr  in  ADDR_W  VGA read address.
- dump_start  in  1  single-cycle pulse (already edge-detected); starts a frame dump.
- dump_abort  in  1  level; stops the dump at the next byte boundary.
- bram_rd_addr  out  ADDR_W  registered BRAM read address.
- bram_rd_data  in  12  BRAM read data.
- tx_busy  in  1  uart_tx busy.
- start_tx  out  1  one-cycle pulse to uart_tx.
- tx_data  out  8  byte to transmit; stable from the start_tx pulse until tx_busy falls.
- vga_grant  out  1  port was given to VGA last cycle.
- dump_active  out  1  a dump is in progress.
- dump_done  out  1  one-cycle pulse when a full frame has been sent.

Behaviour:
- Reset (async, rst_db=0):
  - bram_rd_addr=0, start_tx=0, tx_data=0, vga_grant=0, dump_active=0, dump_done=0.
  - FSM=IDLE, pixel counter=0, latency pipe cleared.
- Arbitration, evaluated every cycle:
  - vga_req=1: bram_rd_addr<=vga_addr and vga_grant<=1. Any dump read is deferred.
  - vga_req=0 and FSM=REQ: bram_rd_addr<=pix_cnt, a dump read tag is launched, vga_grant<=0.
  - Otherwise bram_rd_addr holds its value and vga_grant<=0.
  - VGA is never stalled. The dump may starve indefinitely without error.
- Read capture:
  - The dump tag travels through an RD_LAT+1 stage shift pipe.
  - When the tag exits, bram_rd_data is latched into a 12-bit pixel register.
  - Data returned for VGA-granted cycles is ignored by this block.
- FSM states:
  - IDLE: dump_active=0. On dump_start: pix_cnt<=0, go to REQ.
  - REQ: wait for vga_req=0, issue the read, go to WAIT.
  - WAIT: wait for the tag to exit, capture the pixel, go to SEND_HI.
  - SEND_HI: wait until tx_busy=0, then pulse start_tx with tx_data={4'h0,pix[11:8]}, go to ACK_HI.
  - ACK_HI: wait for tx_busy=1, then go to DRAIN_HI.
  - DRAIN_HI: wait for tx_busy=0, then go to SEND_LO.
  - SEND_LO: pulse start_tx with tx_data=pix[7:0], go to ACK_LO.
  - ACK_LO: wait for tx_busy=1, then go to DRAIN_LO.
  - DRAIN_LO: on tx_busy=0:
    - if pix_cnt==NPIX-1: pulse dump_done, go to IDLE;
    - else if dump_abort=1: go to IDLE (no dump_done);
    - else pix_cnt<=pix_cnt+1, go to REQ.
- dump_active=1 in every state except IDLE.
- dump_start while dump_active=1 is ignored and does not restart the counter.
- Abort boundaries:
  - dump_abort in REQ, WAIT or SEND_HI: go to IDLE immediately; no byte of that pixel is sent.
  - dump_abort after the high byte has been sent: the low byte still completes, so the stream never ends on a half pixel.
- pix_cnt is ADDR_W wide and never exceeds NPIX-1; there is no wrap-around past the frame.
- Only one start_tx pulse is issued per byte; start_tx is never asserted while tx_busy=1.
- Latency: with vga_req=0 and tx idle, the first start_tx comes RD_LAT+3 cycles after dump_start.
- Reset mid-dump returns everything to reset values immediately. A byte already in flight in uart_tx is not recalled.

Test Plan:
- Idle VGA only: vga_req=1, vga_addr stepping 0..639 -> bram_rd_addr equals vga_addr delayed one cycle; vga_grant=1; start_tx never pulses.
- Single-pixel frame (NPIX=1): BRAM[0]=12'hABC, vga_req=0 -> start_tx with tx_data=8'h0A, then 8'hBC after the tx_busy cycle; dump_done pulses once; dump_active falls the same cycle.
- Contention: vga_req held high for 50 cycles after dump_start -> no dump read during those cycles; dump read to address 0 on the first cycle vga_req=0; data still correct.
- Full frame (NPIX=76800): uart_tx model busy for 143 cycles per byte -> exactly 153600 start_tx pulses, address sequence 0..76799 with no gaps, one dump_done.
- Abort and retrigger: dump_abort raised while in ACK_HI of pixel 5 -> low byte of pixel 5 is sent, then IDLE, no dump_done. A dump_start pulse issued mid-dump (before the abort) is ignored. A dump_start after IDLE restarts at address 0.
- Async reset: rst_db low during DRAIN_LO of pixel 100 -> all outputs are 0 within the same cycle; after release, dump_start restarts from address 0.
